// File: rtl/mips_defs.sv
// Shared MIPS core definitions: opcodes, writeback-select codes and load types.
package mips_defs;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] JAL = 6'b000011;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC8 = 2'd2;

  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_type_e;

  // Unknown opcodes on the load path fall back to a full-word load.
  function automatic ld_type_e decode_load(input logic [5:0] op);
    case (op)
      LB:      return LD_B;
      LBU:     return LD_BU;
      LH:      return LD_H;
      LHU:     return LD_HU;
      default: return LD_W;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load-lane extraction and alignment check for a 32-bit DM word.
module load_ext
  import mips_defs::*;
(
  input  ld_type_e    ld_type_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = word_i[{addr_i, 3'b000} +: 8];
    half_sel     = addr_i[1] ? word_i[31:16] : word_i[15:0];
    data_o       = word_i;
    misaligned_o = 1'b0;
    case (ld_type_i)
      LD_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: data_o = {24'h0, byte_sel};
      LD_H: begin
        data_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_i[0];
      end
      LD_HU: begin
        data_o       = {16'h0, half_sel};
        misaligned_o = addr_i[0];
      end
      default: misaligned_o = (addr_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: load extraction, writeback mux and GRF write control.
module mem_wb_stage
  import mips_defs::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_m,
  input  logic [WIDTH-1:0] pc_m,
  input  logic [WIDTH-1:0] instr_m,
  input  logic [WIDTH-1:0] alu_out_m,
  input  logic [WIDTH-1:0] dm_rdata_m,
  input  logic             regwrite_m,
  input  logic [4:0]       dst_m,
  input  logic [1:0]       wbsel_m,
  output logic             valid_w,
  output logic [WIDTH-1:0] pc_w,
  output logic             regwrite_w,
  output logic [4:0]       dst_w,
  output logic [WIDTH-1:0] wdata_w,
  output logic             addr_exc_w
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       dst_q, dst_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             addr_exc_q, addr_exc_d;

  logic [31:0] ld_data;
  logic        ld_misaligned;
  logic        misaligned;
  logic        unused_instr;

  assign unused_instr = ^instr_m[25:0];

  load_ext u_load_ext (
    .ld_type_i    (decode_load(instr_m[31:26])),
    .addr_i       (alu_out_m[1:0]),
    .word_i       (dm_rdata_m),
    .data_o       (ld_data),
    .misaligned_o (ld_misaligned)
  );

  assign misaligned = (wbsel_m == WBSEL_MEM) && ld_misaligned;

  // An invalid MEM instruction captures as a bubble but still carries its pc.
  always_comb begin
    valid_d    = 1'b0;
    pc_d       = pc_m;
    regwrite_d = 1'b0;
    dst_d      = 5'd0;
    wdata_d    = '0;
    addr_exc_d = 1'b0;
    if (valid_m) begin
      valid_d    = 1'b1;
      dst_d      = dst_m;
      addr_exc_d = misaligned;
      regwrite_d = regwrite_m && (dst_m != 5'd0) && !misaligned;
      case (wbsel_m)
        WBSEL_MEM: wdata_d = ld_data;
        WBSEL_PC8: wdata_d = pc_m + 32'd8;
        default:   wdata_d = alu_out_m;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      regwrite_q <= 1'b0;
      dst_q      <= 5'd0;
      wdata_q    <= '0;
      addr_exc_q <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      pc_q       <= pc_m;
      regwrite_q <= 1'b0;
      dst_q      <= 5'd0;
      wdata_q    <= '0;
      addr_exc_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      regwrite_q <= regwrite_d;
      dst_q      <= dst_d;
      wdata_q    <= wdata_d;
      addr_exc_q <= addr_exc_d;
    end
  end

  assign valid_w    = valid_q;
  assign pc_w       = pc_q;
  assign regwrite_w = regwrite_q;
  assign dst_w      = dst_q;
  assign wdata_w    = wdata_q;
  assign addr_exc_w = addr_exc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_m, regwrite_m;
  logic [31:0] pc_m, instr_m, alu_out_m, dm_rdata_m;
  logic [4:0]  dst_m;
  logic [1:0]  wbsel_m;
  logic        valid_w, regwrite_w, addr_exc_w;
  logic [31:0] pc_w, wdata_w;
  logic [4:0]  dst_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_m(valid_m),
    .pc_m(pc_m), .instr_m(instr_m), .alu_out_m(alu_out_m), .dm_rdata_m(dm_rdata_m),
    .regwrite_m(regwrite_m), .dst_m(dst_m), .wbsel_m(wbsel_m),
    .valid_w(valid_w), .pc_w(pc_w), .regwrite_w(regwrite_w), .dst_w(dst_w),
    .wdata_w(wdata_w), .addr_exc_w(addr_exc_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [5:0] op,
                       input logic [31:0] alu, input logic [31:0] rd, input logic rw,
                       input logic [4:0] dst, input logic [1:0] wb);
    valid_m    = v;
    pc_m       = pc;
    instr_m    = {op, 26'h0};
    alu_out_m  = alu;
    dm_rdata_m = rd;
    regwrite_m = rw;
    dst_m      = dst;
    wbsel_m    = wb;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] pc,
                         input logic rw, input logic [4:0] dst, input logic [31:0] wd,
                         input logic exc);
    chk({tag, ".valid"}, {31'h0, valid_w}, {31'h0, v});
    chk({tag, ".pc"}, pc_w, pc);
    chk({tag, ".regwrite"}, {31'h0, regwrite_w}, {31'h0, rw});
    chk({tag, ".dst"}, {27'h0, dst_w}, {27'h0, dst});
    chk({tag, ".wdata"}, wdata_w, wd);
    chk({tag, ".exc"}, {31'h0, addr_exc_w}, {31'h0, exc});
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 6'(LW_OP()), $urandom, $urandom, 1'b1, 5'($urandom), 2'($urandom));
      stall = 1'($urandom); flush = 1'($urandom);
      step();
      chk_all("reset", 1'b0, 32'h0000_3000, 1'b0, 5'd0, 32'h0, 1'b0);
    end
    stall = 1'b0; flush = 1'b0; rst = 1'b1;
    drive(1'b1, 32'h400, 6'b100011, 32'h100, 32'hCAFE_BABE, 1'b1, 5'd5, 2'd1);
    step();
    chk_all("first_lw", 1'b1, 32'h400, 1'b1, 5'd5, 32'hCAFE_BABE, 1'b0);

    drive(1'b1, 32'h404, 6'b100000, 32'h3, 32'h80FF_7F01, 1'b1, 5'd4, 2'd1);
    step();
    chk_all("lb", 1'b1, 32'h404, 1'b1, 5'd4, 32'hFFFF_FF80, 1'b0);
    drive(1'b1, 32'h408, 6'b100100, 32'h3, 32'h80FF_7F01, 1'b1, 5'd6, 2'd1);
    step();
    chk_all("lbu", 1'b1, 32'h408, 1'b1, 5'd6, 32'h0000_0080, 1'b0);
    drive(1'b1, 32'h40C, 6'b100000, 32'h1, 32'h80FF_7F01, 1'b1, 5'd6, 2'd1);
    step();
    chk("lb_lane1", wdata_w, 32'h0000_007F);

    drive(1'b1, 32'h410, 6'b100001, 32'h2, 32'h8001_FFFF, 1'b1, 5'd7, 2'd1);
    step();
    chk_all("lh", 1'b1, 32'h410, 1'b1, 5'd7, 32'hFFFF_8001, 1'b0);
    drive(1'b1, 32'h414, 6'b100101, 32'h2, 32'h8001_FFFF, 1'b1, 5'd7, 2'd1);
    step();
    chk("lhu", wdata_w, 32'h0000_8001);
    drive(1'b1, 32'h418, 6'b100001, 32'h1, 32'h8001_FFFF, 1'b1, 5'd7, 2'd1);
    step();
    chk_all("lh_mis", 1'b1, 32'h418, 1'b0, 5'd7, 32'hFFFF_FFFF, 1'b1);
    drive(1'b1, 32'h41C, 6'b100011, 32'h6, 32'h1122_3344, 1'b1, 5'd7, 2'd1);
    step();
    chk_all("lw_mis", 1'b1, 32'h41C, 1'b0, 5'd7, 32'h1122_3344, 1'b1);
    // misaligned address on a non-load result is not an exception
    drive(1'b1, 32'h420, 6'b100011, 32'h7, 32'h1122_3344, 1'b1, 5'd7, 2'd0);
    step();
    chk_all("alu_odd", 1'b1, 32'h420, 1'b1, 5'd7, 32'h7, 1'b0);

    drive(1'b1, 32'hFFFF_FFFC, 6'b000011, 32'h0, 32'h0, 1'b1, 5'd31, 2'd2);
    step();
    chk_all("jal_wrap", 1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, 32'h0000_0004, 1'b0);
    drive(1'b1, 32'h424, 6'b001101, 32'h55, 32'h0, 1'b1, 5'd0, 2'd0);
    step();
    chk_all("ori_r0", 1'b1, 32'h424, 1'b0, 5'd0, 32'h55, 1'b0);
    drive(1'b1, 32'h428, 6'b001101, 32'h99, 32'h0, 1'b1, 5'd3, 2'd3);
    step();
    chk("wbsel3", wdata_w, 32'h99);

    drive(1'b0, 32'h42C, 6'b100011, 32'h10, 32'hDEAD_BEEF, 1'b1, 5'd8, 2'd1);
    step();
    chk_all("invalid", 1'b0, 32'h42C, 1'b0, 5'd0, 32'h0, 1'b0);

    drive(1'b1, 32'h500, 6'b000000, 32'h77, 32'h0, 1'b1, 5'd9, 2'd0);
    step();
    chk_all("pre_stall", 1'b1, 32'h500, 1'b1, 5'd9, 32'h77, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(i * 4), 6'b100011, 32'h1, 32'hAAAA_0000 + 32'(i), 1'b1,
            5'(10 + i), 2'd1);
      step();
      chk_all("stall", 1'b1, 32'h500, 1'b1, 5'd9, 32'h77, 1'b0);
    end
    flush = 1'b1;
    drive(1'b1, 32'h700, 6'b000000, 32'h33, 32'h0, 1'b1, 5'd12, 2'd0);
    step();
    chk_all("flush_stall", 1'b0, 32'h700, 1'b0, 5'd0, 32'h0, 1'b0);
    stall = 1'b0; flush = 1'b0;

    drive(1'b1, 32'h800, 6'b100011, 32'h10, 32'h1234_5678, 1'b1, 5'd8, 2'd1);
    step();
    chk_all("b2b_lw", 1'b1, 32'h800, 1'b1, 5'd8, 32'h1234_5678, 1'b0);
    drive(1'b1, 32'h804, 6'b000000, 32'h5, 32'h0, 1'b1, 5'd9, 2'd0);
    step();
    chk_all("b2b_addu", 1'b1, 32'h804, 1'b1, 5'd9, 32'h0000_0005, 1'b0);

    rst = 1'b0;
    step();
    chk_all("reset_again", 1'b0, 32'h0000_3000, 1'b0, 5'd0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic int LW_OP();
    return 35;
  endfunction

endmodule
